// File: rtl/fir_sample_feeder.sv
// Sample FIFO and pacing stage ahead of the FIR filter: presents one sample every PERIOD clocks.
// Optional macro FIR_FEEDER_ZERO_FILL_EN: on underrun, keep running on zero samples instead of re-priming.
module fir_sample_feeder #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PERIOD    = 20,
  parameter int unsigned PRIME_LVL = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [DATA_W-1:0]   out_sig,
  output logic                       out_run,
  output logic                       out_strobe,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       underrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(PERIOD);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state, state_nxt;
  logic [CW-1:0]             cnt, cnt_nxt;
  logic signed [DATA_W-1:0]  mem [DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [LW-1:0]             level_nxt;
  logic signed [DATA_W-1:0]  sig_nxt;
  logic                      run_nxt, strobe_nxt, underrun_nxt;
  logic                      full, empty, primed, cnt_last;
  logic                      push, pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign primed   = (32'(level) >= PRIME_LVL);
  assign cnt_last = (cnt == CW'(PERIOD - 1));
  assign in_ready = !full;
  assign push     = in_valid && !full;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    sig_nxt      = out_sig;
    run_nxt      = out_run;
    strobe_nxt   = 1'b0;
    underrun_nxt = 1'b0;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        run_nxt = 1'b0;
        if (primed) begin
          pop        = 1'b1;
          sig_nxt    = mem[rd_ptr];
          strobe_nxt = 1'b1;
          run_nxt    = 1'b1;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        if (cnt_last) begin
          cnt_nxt = '0;
          if (!empty) begin
            pop        = 1'b1;
            sig_nxt    = mem[rd_ptr];
            strobe_nxt = 1'b1;
          end else begin
            underrun_nxt = 1'b1;
`ifdef FIR_FEEDER_ZERO_FILL_EN
            sig_nxt    = '0;
            strobe_nxt = 1'b1;
`else
            run_nxt    = 1'b0;
            state_nxt  = IDLE;
`endif
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      out_sig    <= '0;
      out_run    <= 1'b0;
      out_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      level      <= level_nxt;
      out_sig    <= sig_nxt;
      out_run    <= run_nxt;
      out_strobe <= strobe_nxt;
      underrun   <= underrun_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule
